sync_ram: RTL and testbench

- Single-port synchronous RAM: 1024 words x 8 bits, one write-enable, registered read data.
- General-purpose on-chip storage for datapath or buffering blocks in a single clock domain.
- After reset, a built-in clear engine zeroes every location and then raises ready.
- Users must hold off accesses until ready is high.

---
 rtl/sync_ram.sv | 118 +++++++++++
 tb/tb_sync_ram.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_ram.sv
// Purpose : single-port synchronous RAM (2**ADDR_W x DATA_W) that clears itself to zero after every reset.
// Latency : 1 cycle; a read or write at edge N updates dout at edge N (read-first on writes).
// Backpres: none; callers must hold off accesses until ready=1, and accesses before then are dropped.
//
// Ports:
//   clk   - rising-edge clock, all state changes on posedge
//   rst_n - synchronous active-low reset
//   din   - write data
//   addr  - read/write address
//   w_en  - 1 = write din to mem[addr], 0 = read mem[addr]
//   dout  - registered read data (old contents during a write)
//   ready - high once the clear sweep has finished
module sync_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] addr,
    input  logic              w_en,
    output logic [DATA_W-1:0] dout,
    output logic              ready
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic [DATA_W-1:0]   r_dout;

    // Shared write port: the clear engine and the user both write through it.
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_din;

    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    // State, pointer and ready registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state and write-port steering.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready_nxt = r_ready;
        w_mem_we    = 1'b0;
        w_mem_addr  = addr;
        w_mem_din   = din;

        case (r_state)
            ST_CLEAR: begin
                // User inputs are ignored; sweep one word per cycle.
                w_mem_we   = 1'b1;
                w_mem_addr = r_ptr;
                w_mem_din  = '0;
                w_ptr_nxt  = r_ptr + PTR_ONE;
                if (r_ptr == PTR_MAX) begin
                    w_state_nxt = ST_READY;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_READY: begin
                w_mem_we = w_en;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Storage array. No reset on the array itself; the clear sweep does that.
    // Writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // Read register. Sampling the array with a non-blocking read in the same
    // edge as a write yields the old word, i.e. read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (r_state == ST_READY) begin
            r_dout <= r_mem[addr];
        end else begin
            r_dout <= '0;
        end
    end

    assign dout  = r_dout;
    assign ready = r_ready;

endmodule

// File: tb/tb_sync_ram.sv
module tb_sync_ram;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 10;
    localparam int CLEAR_CYC = 1024;
    localparam int BUDGET    = 2000;
    localparam int NVEC      = 24;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic              w_en;
    logic [DATA_W-1:0] dout;
    logic              ready;

    int n_cmp  = 0;
    int n_fail = 0;

    sync_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .addr  (addr),
        .w_en  (w_en),
        .dout  (dout),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Count edges until ready rises (bounded) while watching dout stays 0.
    task automatic wait_ready(input string name);
        int  n;
        logic dout_bad;
        n        = 0;
        dout_bad = 1'b0;
        while (ready !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
            if (ready !== 1'b1 && dout !== '0) dout_bad = 1'b1;
        end
        check({name, "_cycles"}, n, CLEAR_CYC);
        check({name, "_dout_zero"}, {31'd0, dout_bad}, 32'd0);
    endtask

    task automatic rd(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        w_en = 1'b0;
        addr = a;
        din  = '0;
        tick();
        check(name, dout, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 10'd1010, 8'd210,  8'd0};
        vecs[1]  = '{1'b1, 10'd1000, 8'd110,  8'd0};
        vecs[2]  = '{1'b1, 10'd788,  8'd158,  8'd0};
        vecs[3]  = '{1'b0, 10'd1010, 8'd0,    8'd210};
        vecs[4]  = '{1'b0, 10'd1000, 8'd0,    8'd110};
        vecs[5]  = '{1'b0, 10'd788,  8'hFF,   8'd158};
        vecs[6]  = '{1'b0, 10'd788,  8'h00,   8'd158};
        vecs[7]  = '{1'b1, 10'd5,    8'h33,   8'h00};
        vecs[8]  = '{1'b1, 10'd5,    8'hA5,   8'h33};
        vecs[9]  = '{1'b0, 10'd5,    8'h00,   8'hA5};
        vecs[10] = '{1'b1, 10'd0,    8'h01,   8'h00};
        vecs[11] = '{1'b1, 10'd1023, 8'h80,   8'h00};
        vecs[12] = '{1'b0, 10'd0,    8'h00,   8'h01};
        vecs[13] = '{1'b0, 10'd1023, 8'h00,   8'h80};
        vecs[14] = '{1'b0, 10'd1,    8'h00,   8'h00};
        vecs[15] = '{1'b0, 10'd511,  8'h00,   8'h00};
        vecs[16] = '{1'b0, 10'd3,    8'h00,   8'h00};
        vecs[17] = '{1'b1, 10'd1010, 8'h5A,   8'd210};
        vecs[18] = '{1'b0, 10'd1010, 8'h00,   8'h5A};
        vecs[19] = '{1'b1, 10'd512,  8'hC3,   8'h00};
        vecs[20] = '{1'b0, 10'd0,    8'h00,   8'h01};
        vecs[21] = '{1'b0, 10'd512,  8'h00,   8'hC3};
        vecs[22] = '{1'b1, 10'd100,  8'h7E,   8'h00};
        vecs[23] = '{1'b0, 10'd100,  8'h00,   8'h7E};

        rst_n = 1'b0;
        w_en  = 1'b0;
        din   = '0;
        addr  = '0;

        // Reset then clear, with a write attempt held during the sweep.
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_dout", dout, 32'd0);
        w_en  = 1'b1;
        din   = 8'hFF;
        addr  = 10'd3;
        rst_n = 1'b1;
        wait_ready("clear1");
        check("ready_high", {31'd0, ready}, 32'd1);

        rd("clr_rd0", 10'd0, 8'h00);
        rd("clr_rd511", 10'd511, 8'h00);
        rd("clr_rd1023", 10'd1023, 8'h00);
        rd("clr_rd3", 10'd3, 8'h00);

        for (int i = 0; i < NVEC; i++) begin
            w_en = vecs[i].we;
            addr = vecs[i].a;
            din  = vecs[i].d;
            tick();
            check($sformatf("vec%0d", i), dout, vecs[i].exp);
        end

        // Mid-operation reset: one-cycle pulse in READY.
        w_en  = 1'b0;
        addr  = 10'd100;
        rst_n = 1'b0;
        tick();
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_dout", dout, 32'd0);
        rst_n = 1'b1;
        wait_ready("clear2");
        rd("midrst_rd100", 10'd100, 8'h00);
        rd("midrst_rd1023", 10'd1023, 8'h00);

        // Reset partway through a sweep must restart the pointer.
        rd("pre_wr", 10'd900, 8'h00);
        w_en = 1'b1; addr = 10'd900; din = 8'h99;
        tick();
        rst_n = 1'b0;
        w_en  = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (500) tick();
        check("partial_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready("clear3");
        rd("restart_rd900", 10'd900, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
